// File: rtl/multicore_system_core_rom_loader.sv
// Boot-image loader: streams words into a program-memory window over its s2 port while holding the core in reset.
// Define LOADER_VERIFY_EN to add a readback pass that re-sums the window and flags a checksum mismatch.
module multicore_system_core_rom_loader #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum
);
`ifdef LOADER_VERIFY_EN
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LOAD, S_DONE, S_VERIFY} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LOAD, S_DONE} state_t;
`endif

    localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              cs_q, cs_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [31:0]       sum_q, sum_d;
    logic              hs;
    logic              illegal;
    logic [ADDR_W+1:0] end_addr;
`ifdef LOADER_VERIFY_EN
    logic [ADDR_W:0]   vidx_q, vidx_d;
    logic [ADDR_W:0]   vcnt_q, vcnt_d;
    logic              rd1_q, rd1_d;
    logic              rd2_q, rd2_d;
    logic [31:0]       vsum_q, vsum_d;
`else
    logic              unused_rd;
    assign unused_rd = ^mem_readdata;
`endif

    assign in_ready       = (state_q == S_LOAD) && !last_q;
    assign hs             = in_valid && in_ready;
    assign end_addr       = {2'b00, base_q} + {1'b0, count_q};
    assign illegal        = (count_q == '0) || ({1'b0, count_q} > DEPTH_W) || (end_addr > DEPTH_W);
    assign mem_address    = addr_q;
    assign mem_writedata  = wdata_q;
    assign mem_write      = write_q;
    assign mem_chipselect = cs_q;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign core_hold      = hold_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign error          = error_q;
    assign checksum       = sum_q;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        idx_d   = idx_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = 1'b0;
        cs_d    = 1'b0;
        hold_d  = hold_q;
        done_d  = 1'b0;
        error_d = error_q;
        sum_d   = sum_q;
`ifdef LOADER_VERIFY_EN
        vidx_d  = vidx_q;
        vcnt_d  = vcnt_q;
        rd1_d   = 1'b0;
        rd2_d   = rd1_q;
        vsum_d  = vsum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    count_d = word_count;
                    idx_d   = '0;
                    last_d  = 1'b0;
                    error_d = 1'b0;
                    sum_d   = '0;
                    hold_d  = 1'b1;
                    state_d = S_CHECK;
`ifdef LOADER_VERIFY_EN
                    vidx_d  = '0;
                    vcnt_d  = '0;
                    vsum_d  = '0;
`endif
                end
            end
            S_CHECK: begin
                if (illegal) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    write_d = 1'b1;
                    cs_d    = 1'b1;
                    addr_d  = base_q + idx_q[ADDR_W-1:0];
                    wdata_d = in_data;
                    idx_d   = idx_q + ONE;
                    sum_d   = sum_q + in_data;
                    if (idx_q == count_q - ONE) last_d = 1'b1;
                end
                // last_q means the final strobe is on the port this cycle
                if (last_q) begin
`ifdef LOADER_VERIFY_EN
                    state_d = S_VERIFY;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef LOADER_VERIFY_EN
            S_VERIFY: begin
                if (vidx_q != count_q) begin
                    cs_d   = 1'b1;
                    addr_d = base_q + vidx_q[ADDR_W-1:0];
                    vidx_d = vidx_q + ONE;
                    rd1_d  = 1'b1;
                end
                // rd2_q marks the cycle in which the memory presents data for an earlier address
                if (rd2_q) begin
                    vsum_d = vsum_q + mem_readdata;
                    vcnt_d = vcnt_q + ONE;
                    if (vcnt_q == count_q - ONE) begin
                        if (vsum_d != sum_q) error_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_DONE && state_q != S_DONE) begin
            done_d = 1'b1;
            hold_d = error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            cs_q    <= 1'b0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            sum_q   <= '0;
`ifdef LOADER_VERIFY_EN
            vidx_q  <= '0;
            vcnt_q  <= '0;
            rd1_q   <= 1'b0;
            rd2_q   <= 1'b0;
            vsum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            cs_q    <= cs_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            error_q <= error_d;
            sum_q   <= sum_d;
`ifdef LOADER_VERIFY_EN
            vidx_q  <= vidx_d;
            vcnt_q  <= vcnt_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            vsum_q  <= vsum_d;
`endif
        end
    end
endmodule

// File: tb/tb_multicore_system_core_rom_loader.sv
// Scoreboard bench for the ROM loader: a driver issues loads and queues expected writes/completions, a monitor checks them.
module tb_multicore_system_core_rom_loader;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4096;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic [31:0]       in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;
    logic [31:0]       mem_readdata;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [31:0]       checksum;

    multicore_system_core_rom_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .core_hold(core_hold), .busy(busy), .done(done),
        .error(error), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; bit last; } wr_t;
    typedef struct { bit err; logic [31:0] sum; } dn_t;
    wr_t wr_q[$];
    dn_t dn_q[$];

    int  pass_cnt = 0;
    int  total_cnt = 0;
    int  done_cnt = 0;
    bit  mon_en = 1'b0;
    bit  prev_done = 1'b0;
    bit  hold_pending = 1'b0;
    bit  hold_exp = 1'b1;
    bit  corrupt_on;
    logic [ADDR_W-1:0] corrupt_addr;

    // Synchronous-read memory model behind the s2 port; can damage one word on write
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_chipselect && mem_write)
            mem[mem_address] <= (corrupt_on && mem_address == corrupt_addr) ? (mem_writedata ^ 32'h100) : mem_writedata;
        if (mem_chipselect && !mem_write)
            mem_readdata <= mem[mem_address];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_write) begin
                chk("wr_chipselect", 32'(mem_chipselect), 32'd1);
                chk("wr_byteenable", 32'(mem_byteenable), 32'hF);
                chk("wr_clken", 32'(mem_clken), 32'd1);
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 32'(mem_address), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("wr_addr", 32'(mem_address), 32'(e.addr));
                    chk("wr_data", mem_writedata, e.data);
                    if (e.last) chk("in_ready_after_last", 32'(in_ready), 32'd0);
                end
            end
            if (hold_pending) begin
                chk("core_hold_after_done", 32'(core_hold), 32'(hold_exp));
                chk("busy_after_done", 32'(busy), 32'd0);
                hold_pending = 1'b0;
            end
            if (done) begin
                done_cnt++;
                chk("done_single_pulse", 32'(prev_done), 32'd0);
                chk("busy_in_done", 32'(busy), 32'd1);
                chk("writes_outstanding", 32'(wr_q.size()), 32'd0);
                if (dn_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    dn_t d;
                    d = dn_q.pop_front();
                    chk("error", 32'(error), 32'(d.err));
                    chk("checksum", checksum, d.sum);
                    hold_exp = d.err;
                    hold_pending = 1'b1;
                end
            end
            prev_done = done;
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        chk({tag, "_mem_cs"}, 32'(mem_chipselect), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_address), 32'd0);
        chk({tag, "_mem_wdata"}, mem_writedata, 32'd0);
        chk({tag, "_byteenable"}, 32'(mem_byteenable), 32'hF);
        chk({tag, "_clken"}, 32'(mem_clken), 32'd1);
        chk({tag, "_core_hold"}, 32'(core_hold), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_checksum"}, checksum, 32'd0);
    endtask

    // vmode: 0 = valid held high, 1 = valid toggles, 2 = random valid
    task automatic run_load(input int base, input int cnt, input int vmode, input bit fixed,
                            input bit spur, input int abort_after, input bit corrupt);
        bit legal;
        bit hs;
        int i;
        int cyc;
        int tgt;
        logic [31:0] sum;
        wr_t e;
        dn_t d;
        legal = (cnt >= 1) && (cnt <= DEPTH) && (base + cnt <= DEPTH);
        sum = 32'd0;
        tgt = done_cnt + 1;
        corrupt_on = corrupt;
        corrupt_addr = ADDR_W'(base + 1);
        @(negedge clk);
        start = 1'b1;
        base_addr = ADDR_W'(base);
        word_count = (ADDR_W+1)'(cnt);
        if (!legal) begin
            d.err = 1'b1;
            d.sum = 32'd0;
            dn_q.push_back(d);
        end
        @(negedge clk);
        start = 1'b0;
        i = 0;
        cyc = 0;
        if (legal) begin
            while (i < cnt && cyc < cnt * 4 + 20) begin
                case (vmode)
                    0: in_valid = 1'b1;
                    1: in_valid = (cyc % 2 == 0);
                    default: in_valid = 1'($urandom_range(0, 1));
                endcase
                in_data = fixed ? 32'(i + 1) : $urandom;
                start = spur && (i == 1);
                if (start) base_addr = ADDR_W'($urandom);
                #1 hs = in_valid && in_ready;
                @(posedge clk);
                if (hs) begin
                    e.addr = ADDR_W'(base + i);
                    e.data = in_data;
                    e.last = (i == cnt - 1);
                    wr_q.push_back(e);
                    sum = sum + in_data;
                    i++;
                    if (i == cnt) begin
                        d.err = corrupt;
                        d.sum = sum;
                        dn_q.push_back(d);
                    end
                end
                cyc++;
                @(negedge clk);
                start = 1'b0;
                if (abort_after > 0 && i == abort_after) break;
            end
            in_valid = 1'b0;
            if (abort_after == 0 && i < cnt) chk("handshake_timeout", 32'(i), 32'(cnt));
        end
        if (abort_after > 0) begin
            reset_n = 1'b0;
            @(posedge clk);
            wr_q.delete();
            dn_q.delete();
            @(negedge clk);
            check_reset("abort");
            reset_n = 1'b1;
        end else begin
            cyc = 0;
            while (done_cnt < tgt && cyc < 2 * cnt + 60) begin
                @(negedge clk);
                cyc++;
            end
            if (done_cnt < tgt) chk("done_timeout", 32'(done_cnt), 32'(tgt));
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        in_data = '0;
        in_valid = 1'b0;
        corrupt_on = 1'b0;
        corrupt_addr = '0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        reset_n = 1'b1;
        mon_en = 1'b1;

        run_load(12'h010, 4, 0, 1'b1, 1'b0, 0, 1'b0);
        run_load(100, 3, 1, 1'b0, 1'b0, 0, 1'b0);
        run_load(12'hFFE, 3, 0, 1'b0, 1'b0, 0, 1'b0);
        run_load(0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        run_load(0, 4097, 0, 1'b0, 1'b0, 0, 1'b0);
        run_load(0, 4096, 0, 1'b0, 1'b0, 0, 1'b0);
        run_load(200, 5, 0, 1'b0, 1'b0, 2, 1'b0);
        run_load(300, 5, 2, 1'b0, 1'b0, 0, 1'b0);
        run_load(50, 6, 2, 1'b0, 1'b1, 0, 1'b0);
`ifdef LOADER_VERIFY_EN
        run_load(400, 4, 0, 1'b0, 1'b0, 0, 1'b1);
        run_load(400, 4, 2, 1'b0, 1'b0, 0, 1'b0);
`endif
        for (int k = 0; k < 10; k++) begin
            int b;
            int c;
            c = int'($urandom_range(1, 10));
            if ($urandom_range(0, 3) == 0) b = int'($urandom_range(DEPTH - 12, DEPTH - 1));
            else b = int'($urandom_range(0, DEPTH - 16));
            run_load(b, c, 2, 1'b0, (k == 3), 0, 1'b0);
        end
        chk("scoreboard_empty", 32'(wr_q.size() + dn_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
